// File: rtl/stream_rsp_demux_pkg.sv
// rtl/stream_rsp_demux_pkg.sv - shared constants and width helpers for the response demux
package stream_rsp_demux_pkg;

    // Smallest select FIFO that still allows a push and a pop in flight together
    localparam int unsigned MIN_SEL_DEPTH = 2;

    // Width of a fill-level counter able to hold 0..depth inclusive
    function automatic int unsigned cnt_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_sel_fifo.sv
// rtl/stream_sel_fifo.sv - requester-index FIFO with full/empty/count, no fall-through
module stream_sel_fifo
    import stream_rsp_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_bits(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // A full FIFO refuses pushes even when a pop frees a slot this cycle
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and fill-level bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted as valid
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/stream_rsp_demux.sv
// rtl/stream_rsp_demux.sv - steers in-order responses to requesters; STREAM_RSP_DEMUX_OUT_REG_EN adds an output stage
module stream_rsp_demux
    import stream_rsp_demux_pkg::*;
#(
    parameter int unsigned N_OUP      = 2,
    parameter int unsigned LOG_N_OUP  = $clog2(N_OUP),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sel_valid_i,
    output logic                   sel_ready_o,
    input  logic [LOG_N_OUP-1:0]   sel_i,
    input  logic [DATA_WIDTH-1:0]  inp_data_i,
    input  logic                   inp_valid_i,
    output logic                   inp_ready_o,
    output logic [DATA_WIDTH-1:0]  oup_data_o,
    output logic [N_OUP-1:0]       oup_valid_o,
    input  logic [N_OUP-1:0]       oup_ready_i,
    output logic [$clog2(DEPTH):0] outstanding_o,
    output logic                   drop_o
);

    localparam logic [LOG_N_OUP:0] IDX_LIMIT = (LOG_N_OUP + 1)'(N_OUP);

    logic [LOG_N_OUP-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_in_range;
    logic                 pop;
    logic                 drop_d;
    logic                 drop_q;

    stream_sel_fifo #(
        .WIDTH (LOG_N_OUP),
        .DEPTH (DEPTH)
    ) u_sel_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (sel_valid_i),
        .data_i  (sel_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    assign sel_ready_o   = !fifo_full;
    // Indices beyond the last requester are legal in the FIFO and mean "discard"
    assign head_in_range = ({1'b0, head} < IDX_LIMIT);
    assign pop           = inp_valid_i && inp_ready_o;
    assign drop_d        = pop && !head_in_range;
    assign drop_o        = drop_q;

`ifdef STREAM_RSP_DEMUX_OUT_REG_EN
    logic                  st_valid_q;
    logic [LOG_N_OUP-1:0]  st_idx_q;
    logic [DATA_WIDTH-1:0] st_data_q;
    logic                  st_free;

    // Stage can take a new beat when empty or when its current beat leaves now
    assign st_free     = !st_valid_q || oup_ready_i[st_idx_q];
    assign inp_ready_o = st_free && !fifo_empty;
    assign oup_data_o  = st_data_q;

    // Output pipeline stage; discarded responses never occupy it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_valid_q <= 1'b0;
            st_idx_q   <= '0;
            st_data_q  <= '0;
        end else if (st_free) begin
            st_valid_q <= pop && head_in_range;
            if (pop && head_in_range) begin
                st_idx_q  <= head;
                st_data_q <= inp_data_i;
            end
        end
    end

    // One-hot valid decoded from the stage index
    always_comb begin
        oup_valid_o = '0;
        if (st_valid_q) oup_valid_o[st_idx_q] = 1'b1;
    end
`else
    assign oup_data_o = inp_data_i;

    // Combinational steering: valid follows input valid only, ready comes back from the target
    always_comb begin
        oup_valid_o = '0;
        inp_ready_o = 1'b0;
        if (!fifo_empty) begin
            if (head_in_range) begin
                oup_valid_o[head] = inp_valid_i;
                inp_ready_o       = oup_ready_i[head];
            end else begin
                inp_ready_o = 1'b1;
            end
        end
    end
`endif

    // Discard indication lands the cycle after the consuming handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_q <= 1'b0;
        else         drop_q <= drop_d;
    end

endmodule
